// File: rtl/dmem_if.sv
// MEM-stage bus between the core (master) and the data-memory responder (slave).
interface dmem_if;
    logic        mem_w;
    logic        mem_r;
    logic [31:0] addr;
    logic [2:0]  dm_type;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output mem_w, mem_r, addr, dm_type, wdata, input rdata);
    modport slave  (input mem_w, mem_r, addr, dm_type, wdata, output rdata);
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: byte-lane RAM with combinational loads, plus an MMIO
// window holding LEDs, switches, a 64-bit cycle counter and sticky error status.
module dmem_resp #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    dmem_if.slave       bus,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic        err_irq
);
    localparam int AW = $clog2(DEPTH_WORDS);

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  t);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (t)
            3'd1:    return {{16{h[15]}}, h};
            3'd2:    return {16'h0000, h};
            3'd3:    return {{24{b[7]}}, b};
            3'd4:    return {24'h000000, b};
            default: return word;
        endcase
    endfunction

    logic [31:0] ram_q [DEPTH_WORDS];
    logic [15:0] led_q, led_d;
    logic [15:0] sw_q, sw_d;
    logic [63:0] cyc_q, cyc_d;
    logic [1:0]  status_q, status_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic          is_half, is_byte, is_word;
    logic          ram_hit, mmio_hit, misalign, range_err, any_err, access;
    logic          ram_we, mmio_we;
    logic [3:0]    be;
    logic [31:0]   lane_data, mmio_rdata, ram_word;
    logic [AW-1:0] idx;
    logic [3:0]    mmio_off;

    always_comb begin
        is_half   = (bus.dm_type == 3'd1) || (bus.dm_type == 3'd2);
        is_byte   = (bus.dm_type == 3'd3) || (bus.dm_type == 3'd4);
        is_word   = !is_half && !is_byte;
        access    = bus.mem_r || bus.mem_w;
        ram_hit   = ({2'b00, bus.addr[31:2]} < 32'(DEPTH_WORDS));
        mmio_hit  = (bus.addr[31:6] == MMIO_BASE[31:6]);
        // MMIO registers are word-only, so narrower sizes count as misaligned there
        misalign  = (is_word && (bus.addr[1:0] != 2'b00)) ||
                    (is_half && bus.addr[0]) ||
                    (mmio_hit && !is_word);
        range_err = !misalign && !ram_hit && !mmio_hit;
        any_err   = misalign || range_err;
        idx       = bus.addr[AW+1:2];
        mmio_off  = bus.addr[5:2];
        ram_we    = rst && bus.mem_w && ram_hit && !any_err;
        mmio_we   = bus.mem_w && mmio_hit && !any_err;

        be = 4'b1111;
        lane_data = bus.wdata;
        if (is_half) begin
            be        = bus.addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{bus.wdata[15:0]}};
        end else if (is_byte) begin
            be        = 4'b0001 << bus.addr[1:0];
            lane_data = {4{bus.wdata[7:0]}};
        end

        ram_word = ram_q[idx];
        case (mmio_off)
            4'd0:    mmio_rdata = {16'h0000, led_q};
            4'd1:    mmio_rdata = {16'h0000, sw_q};
            4'd2:    mmio_rdata = cyc_q[31:0];
            4'd3:    mmio_rdata = cyc_q[63:32];
            4'd4:    mmio_rdata = {30'd0, status_q};
            4'd5:    mmio_rdata = err_addr_q;
            default: mmio_rdata = 32'h0;
        endcase

        bus.rdata = 32'h0;
        if (rst && bus.mem_r && !any_err) begin
            if (ram_hit)
                bus.rdata = load_extend(ram_word, bus.addr[1:0], bus.dm_type);
            else
                bus.rdata = mmio_rdata;
        end

        led_d      = led_q;
        sw_d       = sw_in;
        cyc_d      = cyc_q + 64'd1;
        status_d   = status_q;
        err_addr_d = err_addr_q;
        if (mmio_we && mmio_off == 4'd0)
            led_d = bus.wdata[15:0];
        if (mmio_we && mmio_off == 4'd4)
            status_d = status_q & ~bus.wdata[1:0];
        // New errors are applied after the W1C so a same-cycle set wins
        if (access && misalign)
            status_d[0] = 1'b1;
        if (access && range_err)
            status_d[1] = 1'b1;
        if (access && any_err && status_q == 2'b00)
            err_addr_d = bus.addr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            led_q      <= '0;
            sw_q       <= '0;
            cyc_q      <= '0;
            status_q   <= '0;
            err_addr_q <= '0;
        end else begin
            led_q      <= led_d;
            sw_q       <= sw_d;
            cyc_q      <= cyc_d;
            status_q   <= status_d;
            err_addr_q <= err_addr_d;
        end
    end

    // RAM contents survive reset; only the write is suppressed
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    ram_q[idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
        end
    end

    assign led_out = led_q;
    assign err_irq = |status_q;
endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: RAM round trips, extension, errors, MMIO, reset.
module tb_dmem_resp;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam logic [31:0] LED   = BASE + 32'h00;
    localparam logic [31:0] SW    = BASE + 32'h04;
    localparam logic [31:0] CYCLO = BASE + 32'h08;
    localparam logic [31:0] CYCHI = BASE + 32'h0C;
    localparam logic [31:0] STAT  = BASE + 32'h10;
    localparam logic [31:0] EADDR = BASE + 32'h14;

    logic        clk;
    logic        rst;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic        err_irq;
    int          vectors;
    int          miscompares;

    dmem_if bus();

    dmem_resp #(.DEPTH_WORDS(1024), .MMIO_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .sw_in(sw_in), .led_out(led_out), .err_irq(err_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus access spanning exactly one rising edge; rdata sampled before the edge.
    task automatic op(input logic w, input logic r, input logic [31:0] a,
                      input logic [2:0] t, input logic [31:0] d, output logic [31:0] rd);
        @(negedge clk);
        bus.mem_w = w; bus.mem_r = r; bus.addr = a; bus.dm_type = t; bus.wdata = d;
        #1 rd = bus.rdata;
        @(posedge clk);
        #1 bus.mem_w = 1'b0; bus.mem_r = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (led_out !== 16'h0) begin
            miscompares++; $display("FAIL reset_led: got %h expected %h", led_out, 16'h0);
        end
        vectors++;
        if (err_irq !== 1'b0) begin
            miscompares++; $display("FAIL reset_irq: got %b expected 0", err_irq);
        end
        rst = 1'b1;
        op(0, 1, CYCLO, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'd0) begin
            miscompares++; $display("FAIL cyc_first: got %h expected %h", rd, 32'd0);
        end
        op(0, 1, CYCLO, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'd1) begin
            miscompares++; $display("FAIL cyc_second: got %h expected %h", rd, 32'd1);
        end
    endtask

    task automatic test_word_rt;
        logic [31:0] rd;
        op(1, 0, 32'h10, 3'd0, 32'h1234_5678, rd);
        op(0, 1, 32'h10, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'h1234_5678) begin
            miscompares++; $display("FAIL lw_10: got %h expected %h", rd, 32'h1234_5678);
        end
        op(1, 0, 32'h11, 3'd3, 32'h0000_00AB, rd);
        op(0, 1, 32'h10, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'h1234_AB78) begin
            miscompares++; $display("FAIL sb_11: got %h expected %h", rd, 32'h1234_AB78);
        end
    endtask

    task automatic test_extend;
        logic [31:0] rd;
        logic [31:0] addrs [5] = '{32'h21, 32'h22, 32'h22, 32'h22, 32'h22};
        logic [2:0]  types [5] = '{3'd3, 3'd3, 3'd4, 3'd1, 3'd2};
        logic [31:0] exps  [5] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_00FF,
                                   32'hFFFF_80FF, 32'h0000_80FF};
        op(1, 0, 32'h20, 3'd0, 32'h80FF_7F01, rd);
        for (int i = 0; i < 5; i++) begin
            op(0, 1, addrs[i], types[i], 0, rd);
            vectors++;
            if (rd !== exps[i]) begin
                miscompares++;
                $display("FAIL ext_%0d: got %h expected %h", i, rd, exps[i]);
            end
        end
        op(1, 0, 32'h22, 3'd1, 32'h1234_BEEF, rd);
        op(0, 1, 32'h20, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'hBEEF_7F01) begin
            miscompares++; $display("FAIL sh_22: got %h expected %h", rd, 32'hBEEF_7F01);
        end
    endtask

    task automatic test_misalign;
        logic [31:0] rd;
        op(1, 0, 32'h30, 3'd0, 32'h1111_2222, rd);
        op(1, 0, 32'h31, 3'd0, 32'hDEAD_BEEF, rd);
        vectors++;
        if (err_irq !== 1'b1) begin
            miscompares++; $display("FAIL mis_irq: got %b expected 1", err_irq);
        end
        op(0, 1, 32'h30, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'h1111_2222) begin
            miscompares++; $display("FAIL mis_nowrite: got %h expected %h", rd, 32'h1111_2222);
        end
        op(0, 1, STAT, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'd1) begin
            miscompares++; $display("FAIL mis_status: got %h expected %h", rd, 32'd1);
        end
        op(0, 1, 32'h43, 3'd1, 0, rd);
        vectors++;
        if (rd !== 32'd0) begin
            miscompares++; $display("FAIL lh_43_rdata: got %h expected %h", rd, 32'd0);
        end
        op(0, 1, STAT, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'd1) begin
            miscompares++; $display("FAIL mis_status2: got %h expected %h", rd, 32'd1);
        end
        op(0, 1, EADDR, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'h31) begin
            miscompares++; $display("FAIL mis_eaddr: got %h expected %h", rd, 32'h31);
        end
        op(1, 0, STAT, 3'd0, 32'd1, rd);
        op(0, 1, STAT, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'd0 || err_irq !== 1'b0) begin
            miscompares++; $display("FAIL mis_clear: got %h/%b expected 0/0", rd, err_irq);
        end
        op(0, 1, LED, 3'd3, 0, rd);
        op(0, 1, STAT, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'd1) begin
            miscompares++; $display("FAIL mmio_byte: got %h expected %h", rd, 32'd1);
        end
        op(1, 0, STAT, 3'd0, 32'd3, rd);
    endtask

    task automatic test_range;
        logic [31:0] rd;
        op(0, 1, 32'h0001_0000, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'd0) begin
            miscompares++; $display("FAIL range_rdata: got %h expected %h", rd, 32'd0);
        end
        op(0, 1, STAT, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'd2) begin
            miscompares++; $display("FAIL range_status: got %h expected %h", rd, 32'd2);
        end
        op(0, 1, EADDR, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'h0001_0000) begin
            miscompares++; $display("FAIL range_eaddr: got %h expected %h", rd, 32'h0001_0000);
        end
    endtask

    task automatic test_rw_same_cycle;
        logic [31:0] rd;
        op(1, 0, 32'h40, 3'd0, 32'h0102_0304, rd);
        op(1, 1, 32'h40, 3'd0, 32'hCAFE_F00D, rd);
        vectors++;
        if (rd !== 32'h0102_0304) begin
            miscompares++; $display("FAIL rw_pre: got %h expected %h", rd, 32'h0102_0304);
        end
        op(0, 1, 32'h40, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'hCAFE_F00D) begin
            miscompares++; $display("FAIL rw_post: got %h expected %h", rd, 32'hCAFE_F00D);
        end
    endtask

    task automatic test_mmio;
        logic [31:0] rd;
        logic [31:0] v0;
        op(1, 0, LED, 3'd0, 32'hFFFF_A5A5, rd);
        vectors++;
        if (led_out !== 16'hA5A5) begin
            miscompares++; $display("FAIL led_out: got %h expected %h", led_out, 16'hA5A5);
        end
        op(0, 1, LED, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'h0000_A5A5) begin
            miscompares++; $display("FAIL led_read: got %h expected %h", rd, 32'h0000_A5A5);
        end
        sw_in = 16'h00C3;
        op(0, 1, SW, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++; $display("FAIL sw_early: got %h expected %h", rd, 32'h0);
        end
        op(0, 1, SW, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'h0000_00C3) begin
            miscompares++; $display("FAIL sw_read: got %h expected %h", rd, 32'h0000_00C3);
        end
        op(0, 1, CYCLO, 3'd0, 0, v0);
        repeat (5) op(0, 0, 32'h0, 3'd0, 0, rd);
        op(0, 1, CYCLO, 3'd0, 0, rd);
        vectors++;
        if (rd !== v0 + 32'd6) begin
            miscompares++; $display("FAIL cyc_delta: got %h expected %h", rd, v0 + 32'd6);
        end
        force dut.cyc_q = 64'h0000_0000_FFFF_FFFF;
        #1 release dut.cyc_q;
        op(0, 1, CYCLO, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL cyc_forced: got %h expected %h", rd, 32'hFFFF_FFFF);
        end
        @(negedge clk);
        bus.mem_r = 1'b1; bus.dm_type = 3'd0; bus.addr = CYCHI;
        #1 rd = bus.rdata;
        vectors++;
        if (rd !== 32'd1) begin
            miscompares++; $display("FAIL cyc_hi_carry: got %h expected %h", rd, 32'd1);
        end
        bus.addr = CYCLO;
        #1 rd = bus.rdata;
        vectors++;
        if (rd !== 32'd0) begin
            miscompares++; $display("FAIL cyc_lo_wrap: got %h expected %h", rd, 32'd0);
        end
        @(posedge clk);
        #1 bus.mem_r = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        op(1, 0, 32'h50, 3'd0, 32'h0000_AAAA, rd);
        op(0, 1, 32'h0002_0000, 3'd0, 0, rd);
        rst = 1'b0;
        op(1, 1, 32'h50, 3'd0, 32'h1234_5678, rd);
        vectors++;
        if (rd !== 32'd0) begin
            miscompares++; $display("FAIL rst_rdata: got %h expected %h", rd, 32'd0);
        end
        rst = 1'b1;
        op(0, 1, CYCLO, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'd0) begin
            miscompares++; $display("FAIL rst_cyc: got %h expected %h", rd, 32'd0);
        end
        vectors++;
        if (led_out !== 16'h0 || err_irq !== 1'b0) begin
            miscompares++; $display("FAIL rst_led_irq: got %h/%b expected 0000/0", led_out, err_irq);
        end
        op(0, 1, STAT, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'd0) begin
            miscompares++; $display("FAIL rst_status: got %h expected %h", rd, 32'd0);
        end
        op(0, 1, 32'h50, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'h0000_AAAA) begin
            miscompares++; $display("FAIL rst_nowrite: got %h expected %h", rd, 32'h0000_AAAA);
        end
        op(0, 1, 32'h10, 3'd0, 0, rd);
        vectors++;
        if (rd !== 32'h1234_AB78) begin
            miscompares++; $display("FAIL rst_keep: got %h expected %h", rd, 32'h1234_AB78);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        sw_in = 16'h0;
        bus.mem_w = 1'b0;
        bus.mem_r = 1'b0;
        bus.addr = 32'h0;
        bus.dm_type = 3'd0;
        bus.wdata = 32'h0;
        test_reset();
        test_word_rt();
        test_extend();
        test_misalign();
        test_range();
        test_rw_same_cycle();
        test_mmio();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the pipelined RISC-V core: the memory end of the core's MEM-stage interface (address, store data, write/read strobes, access type). It returns load data combinationally within the cycle and commits stores on the clock edge. Stores are byte-lane aware. It also decodes a small MMIO window holding an LED register, switch input, a 64-bit cycle counter, and sticky access-error status. It sits beside the core in the top level, where the instruction ROM serves the fetch port.

## Interface
Parameters:
- DEPTH_WORDS, 1024: RAM size in 32-bit words. Power of two.
- MMIO_BASE, 32'hFFFF_0000: base of the 64-byte MMIO window.

Ports:
- clk  in  1  clock. Stores and all registers update on the rising edge.
- rst  in  1  synchronous, active-low reset.
- mem_w  in  1  store strobe from the core MEM stage.
- mem_r  in  1  load strobe from the core MEM stage.
- addr  in  32  byte address from the core.
- dm_type  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned. Other codes are treated as word.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  load data, extended per dm_type. Combinational.
- sw_in  in  16  board switches, sampled into a register each cycle.
- led_out  out  16  LED register.
- err_irq  out  1  OR of the sticky status bits.

## Operation
- Address decode:
  - RAM hit when addr < DEPTH_WORDS*4.
  - MMIO hit when addr[31:6] == MMIO_BASE[31:6].
  - Anything else is a range error.
- Alignment:
  - Word accesses need addr[1:0]==0.
  - Half accesses need addr[0]==0.
  - A violation is a misalign error. It takes priority over a range error.
- RAM store, mem_w=1 and no error: byte enables come from addr[1:0] and size.
  - Word: 4'b1111.
  - Half: 4'b0011 or 4'b1100.
  - Byte: one-hot.
  - The lane data is wdata[7:0] or wdata[15:0], replicated into the selected lanes. Other lanes are unchanged.
- RAM load, mem_r=1 and no error: select the lane from the word at addr[31:2] and extend per dm_type.
- rdata is 0 when:
  - mem_r=0,
  - an error is detected, or
  - rst=0.
- MMIO map, as offsets from MMIO_BASE (word access only; any other size is a misalign error):
  - 0x00 LED: RW. Bits [15:0] are used; upper bits read 0.
  - 0x04 SW: RO. Returns the registered sw_in.
  - 0x08 CYC_LO: RO.
  - 0x0C CYC_HI: RO.
  - 0x10 STATUS: bit0 misalign, bit1 range. Writing a 1 to a bit clears it.
  - 0x14 ERR_ADDR: RO. Holds the address of the first error since the last clear.
  - Other offsets read 0 and ignore writes. They do not raise an error.
- Cycle counter:
  - 64-bit. Increments by 1 every clk while rst=1, and wraps at 2^64-1 to 0.
  - Writes to it are ignored.
- Error capture:
  - Any mem_r or mem_w access with an error sets the matching STATUS bit on the edge.
  - ERR_ADDR loads addr only when STATUS==0 before that edge.
  - An erroneous store writes nothing.
- Simultaneous events:
  - mem_r and mem_w both high: the store commits, and rdata shows the pre-edge contents.
  - STATUS W1C write in the same cycle a new error occurs: the set wins.

## Timing
- The load path is fully combinational from addr, dm_type and mem_r to rdata. The core samples it on the falling edge, so the budget is half a cycle.
- Store latency: one rising edge. A load of the same address in the following cycle returns the new data.
- MMIO register writes are visible on the next cycle's read.
- sw_in register: one cycle of latency.
- On any rising edge with rst=0:
  - led_out=0, cycle counter=0, STATUS=0, ERR_ADDR=0, sw register=0, err_irq=0.
  - RAM contents are preserved, not cleared.
  - A store in a reset cycle is discarded, including when reset is asserted mid-program.
- First cycle after reset release: CYC_LO reads 0. It reads 1 on the next cycle.

## Test plan
- Word round trip:
  - sw 0x12345678 to addr 0x10, then lw 0x10 → rdata 0x12345678.
  - sb 0xAB to 0x11, then lw 0x10 → 0x1234AB78.
- Sign and zero extension:
  - With word 0x80FF7F01 at 0x20: lb 0x21 → 0x0000007F; lb 0x22 → 0xFFFFFFFF; lbu 0x22 → 0x000000FF; lh 0x22 → 0xFFFF80FF; lhu 0x22 → 0x000080FF.
- Misalign:
  - sw 0xDEADBEEF to 0x31 → RAM at 0x30 unchanged, STATUS=1, ERR_ADDR=0x31, err_irq=1.
  - lh 0x43 next → STATUS still 1, ERR_ADDR still 0x31, rdata 0.
  - sw 1 to STATUS → STATUS 0, err_irq 0.
- Range error: lw 0x0001_0000 with DEPTH_WORDS=1024 → rdata 0, STATUS=2.
- MMIO:
  - sw 0xFFFF_A5A5 to LED → led_out 0xA5A5, read back 0x0000A5A5.
  - sw_in=0x00C3 → SW reads 0xC3 one cycle later.
  - CYC_LO increments by N across N cycles; force the counter to 0x0000_0000_FFFF_FFFF → next cycle CYC_HI=1, CYC_LO=0.
- Reset mid-operation:
  - Assert rst=0 together with mem_w to 0x50 → no write.
  - led_out, STATUS and the counter read 0 after release.
  - Data stored before reset at 0x10 still reads back.
